data_mem_master: RTL and testbench

Initiator-side controller for the 16-bit data memory: accepts load/store requests from the core over a valid/ready handshake and sequences them onto the memory's shared-address port (`mem_access_addr`, `mem_write_data`, `mem_write_en`, `mem_read`, `mem_read_data`). It supports single-word accesses and bursts of up to 8 consecutive words (read bursts, constant-fill write bursts), and returns read data through a back-pressurable response channel. It sits between the core's load/store stage and the data memory.

---
 rtl/data_mem_master.sv | 175 +++++++++++++++++
 tb/tb_data_mem_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_master.sv
// data_mem_master: core-side initiator that sequences single and burst load/store requests onto a
// shared-address data memory. Define DMM_RANGE_CHECK_EN to reject requests that run past MEM_WORDS.

module data_mem_master #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int LEN_W     = 3,
   parameter int MEM_WORDS = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic [LEN_W-1:0]  req_len_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_data_o,
   output logic              resp_last_o,
   output logic              resp_err_o,
   output logic [ADDR_W-1:0] mem_access_addr_o,
   output logic [DATA_W-1:0] mem_write_data_o,
   output logic              mem_write_en_o,
   output logic              mem_read_o,
   input  logic [DATA_W-1:0] mem_read_data_i
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      RESP  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              last_beat_s;

`ifdef DMM_RANGE_CHECK_EN
   logic              err_q, err_d;
   logic [ADDR_W:0]   end_addr_s;
   logic              range_bad_s;

   // Extra bit keeps the end-of-burst compare free of wrap-around
   assign end_addr_s  = {1'b0, req_addr_i} + (ADDR_W+1)'(req_len_i);
   assign range_bad_s = ({1'b0, req_addr_i} >= (ADDR_W+1)'(MEM_WORDS)) ||
                        (end_addr_s >= (ADDR_W+1)'(MEM_WORDS));
   assign resp_err_o  = err_q;
`else
   assign resp_err_o  = 1'b0;
`endif

   assign last_beat_s       = (cnt_q == len_q);
   assign req_ready_o       = (state_q == IDLE);
   assign mem_read_o        = (state_q == READ);
   assign mem_write_en_o    = (state_q == WRITE);
   assign resp_valid_o      = (state_q == RESP) || (state_q == DONE);
   assign resp_last_o       = (state_q == DONE) || ((state_q == RESP) && last_beat_s);
   assign resp_data_o       = rdata_q;
   assign mem_access_addr_o = addr_q;
   assign mem_write_data_o  = wdata_q;

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
`ifdef DMM_RANGE_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               len_d   = req_len_i;
               cnt_d   = {LEN_W{1'b0}};
               rdata_d = {DATA_W{1'b0}};
`ifdef DMM_RANGE_CHECK_EN
               if (range_bad_s) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else if (req_write_i) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
`else
               if (req_write_i) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            rdata_d = mem_read_data_i;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready_i && last_beat_s) begin
               state_d = IDLE;
            end else if (resp_ready_i) begin
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = READ;
            end else begin
               state_d = RESP;
            end
         end
         WRITE: begin
            if (last_beat_s) begin
               rdata_d = {DATA_W{1'b0}};
               state_d = DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = WRITE;
            end
         end
         DONE: begin
            if (resp_ready_i) begin
               state_d = IDLE;
`ifdef DMM_RANGE_CHECK_EN
               err_d   = 1'b0;
`endif
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         cnt_q   <= {LEN_W{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
`ifdef DMM_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
`ifdef DMM_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_data_mem_master.sv
// Self-checking bench for data_mem_master: directed scenarios followed by random requests,
// checked against an array-based memory model and cycle-by-cycle protocol expectations.

module tb_data_mem_master;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_len;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic        resp_last;
   logic        resp_err;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;

   logic [15:0] mem [8];
   logic [15:0] ref_mem [8];
   int          checks;
   int          errors;
   int          rd_cnt;
   int          wr_cnt;
   int          both_cnt;

   data_mem_master dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_write_i       (req_write),
      .req_addr_i        (req_addr),
      .req_wdata_i       (req_wdata),
      .req_len_i         (req_len),
      .resp_valid_o      (resp_valid),
      .resp_ready_i      (resp_ready),
      .resp_data_o       (resp_data),
      .resp_last_o       (resp_last),
      .resp_err_o        (resp_err),
      .mem_access_addr_o (mem_access_addr),
      .mem_write_data_o  (mem_write_data),
      .mem_write_en_o    (mem_write_en),
      .mem_read_o        (mem_read),
      .mem_read_data_i   (mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory has no reset and decodes only the low three address bits
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write_en) wr_cnt <= wr_cnt + 1;
      if (mem_read && mem_write_en) both_cnt <= both_cnt + 1;
   end
   assign mem_read_data = mem[mem_access_addr[2:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic range_err(input logic [15:0] a, input logic [2:0] l);
`ifdef DMM_RANGE_CHECK_EN
      return (32'(a) >= 32'd8) || (32'(a) + 32'(l) >= 32'd8);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_last", resp_last, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_mem_addr", mem_access_addr, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
      chk("rst_mem_we", mem_write_en, 0);
      chk("rst_mem_read", mem_read, 0);
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [2:0] l, input logic [15:0] d);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic done_beat(input logic err);
      chk("done_valid", resp_valid, 1);
      chk("done_last", resp_last, 1);
      chk("done_data", resp_data, 0);
      chk("done_err", resp_err, err);
      chk("done_no_mem", {mem_read, mem_write_en}, 0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("after_done_valid", resp_valid, 0);
      chk("after_done_err", resp_err, 0);
      chk("after_done_ready", req_ready, 1);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [2:0] l, input logic [15:0] d);
      int w0;
      logic err;
      logic [15:0] ad;
      w0  = wr_cnt;
      err = range_err(a, l);
      issue(1'b1, a, l, d);
      if (!err) begin
         for (int i = 0; i <= int'(l); i++) begin
            ad = a + 16'(i);
            chk("wr_we", mem_write_en, 1);
            chk("wr_addr", mem_access_addr, ad);
            chk("wr_data", mem_write_data, d);
            chk("wr_no_valid", {resp_valid, req_ready}, 0);
            ref_mem[ad[2:0]] = d;
            @(negedge clk);
         end
      end
      done_beat(err);
      chk("wr_beats", wr_cnt - w0, err ? 0 : int'(l) + 1);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [2:0] l, input int stall);
      int r0;
      logic err;
      logic [15:0] ad;
      logic [15:0] exp_d;
      r0  = rd_cnt;
      err = range_err(a, l);
      issue(1'b0, a, l, 16'h0000);
      if (err) begin
         done_beat(1'b1);
      end else begin
         for (int k = 0; k <= int'(l); k++) begin
            ad = a + 16'(k);
            exp_d = ref_mem[ad[2:0]];
            chk("rd_mem_read", mem_read, 1);
            chk("rd_addr", mem_access_addr, ad);
            chk("rd_not_valid", resp_valid, 0);
            @(negedge clk);
            for (int s = 0; s <= stall; s++) begin
               chk("rd_valid", resp_valid, 1);
               chk("rd_data", resp_data, exp_d);
               chk("rd_last", resp_last, (k == int'(l)) ? 1 : 0);
               chk("rd_err", resp_err, 0);
               chk("rd_quiet", {mem_read, mem_write_en, req_ready}, 0);
               if (s < stall) @(negedge clk);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
         end
         chk("rd_end_valid", resp_valid, 0);
         chk("rd_end_ready", req_ready, 1);
      end
      chk("rd_pulses", rd_cnt - r0, err ? 0 : int'(l) + 1);
   endtask

   initial begin
      int w0;
      clk        = 1'b0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 16'h0000;
      req_wdata  = 16'h0000;
      req_len    = 3'd0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", req_ready, 1);

      // Single write then single read of the same word
      do_write(16'd3, 3'd0, 16'hA5A5);
      do_read(16'd3, 3'd0, 0);

      // Preload k*0x0101 and read a four-beat burst from address 2
      for (int k = 0; k < 8; k++) do_write(16'(k), 3'd0, 16'(k) * 16'h0101);
      do_read(16'd2, 3'd3, 0);

      // Eight-word fill then read back
      do_write(16'd0, 3'd7, 16'h1234);
      do_read(16'd0, 3'd7, 0);

      // Re-preload, then a stalled three-beat burst
      for (int k = 0; k < 8; k++) do_write(16'(k), 3'd0, 16'(k) * 16'h0101);
      do_read(16'd1, 3'd2, 3);

      // Reset during the fourth beat of a fill: that beat still commits
      w0 = wr_cnt;
      issue(1'b1, 16'd0, 3'd7, 16'hBEEF);
      for (int i = 0; i < 3; i++) begin
         chk("rstfill_we", mem_write_en, 1);
         @(negedge clk);
      end
      chk("rstfill_we4", mem_write_en, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[i] = 16'hBEEF;
      chk("rstfill_words", wr_cnt - w0, 4);
      @(negedge clk);
      chk("rstfill_idle", req_ready, 1);
      do_read(16'd0, 3'd7, 0);

      // Burst crossing the end of memory
      do_read(16'd6, 3'd3, 0);

      // Random mix of reads and writes
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(16'($urandom_range(0, 9)), 3'($urandom_range(0, 7)), 16'($urandom));
         else
            do_read(16'($urandom_range(0, 9)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end

      chk("never_both", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
